// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - W-bit add/subtract sequenced one nibble per clock through a 4-bit ripple slice
// The slice result of every RUN edge is merged into a partial register; flags are taken on the last nibble.

module adder_4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cf
);
    logic [4:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < 4; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cf = c[4];
    end
endmodule

module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 sub,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] s,
    output logic                 cf,
    output logic                 of,
    output logic                 zf
);
    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     a_r_q, a_r_d;
    logic [W-1:0]     b_r_q, b_r_d;
    logic             carry_q, carry_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [W-1:0]     partial_q, partial_d;
    logic [W-1:0]     s_q, s_d;
    logic             cf_q, cf_d;
    logic             of_q, of_d;
    logic             zf_q, zf_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [3:0]       slice_a, slice_b, slice_s;
    logic             slice_cf;
    logic [W-1:0]     assembled;

    adder_4 u_slice (
        .a   (slice_a),
        .b   (slice_b),
        .cin (carry_q),
        .s   (slice_s),
        .cf  (slice_cf)
    );

    always_comb begin
        slice_a = a_r_q[{idx_q, 2'b00} +: 4];
        slice_b = b_r_q[{idx_q, 2'b00} +: 4];
        // Partial result with the nibble produced this cycle already merged in.
        assembled = partial_q;
        assembled[{idx_q, 2'b00} +: 4] = slice_s;
    end

    always_comb begin
        state_d   = state_q;
        a_r_d     = a_r_q;
        b_r_d     = b_r_q;
        carry_d   = carry_q;
        idx_d     = idx_q;
        partial_d = partial_q;
        s_d       = s_q;
        cf_d      = cf_q;
        of_d      = of_q;
        zf_d      = zf_q;
        ready_d   = ready_q;
        busy_d    = busy_q;
        done_d    = done_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_r_d     = a;
                    b_r_d     = sub ? ~b : b;
                    carry_d   = sub;
                    idx_d     = '0;
                    partial_d = '0;
                    state_d   = S_RUN;
                    ready_d   = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            S_RUN: begin
                partial_d = assembled;
                carry_d   = slice_cf;
                idx_d     = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    s_d     = assembled;
                    cf_d    = slice_cf;
                    zf_d    = (assembled == '0);
                    of_d    = (a_r_q[W-1] == b_r_q[W-1]) && (assembled[W-1] != a_r_q[W-1]);
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                done_d  = 1'b0;
                ready_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            a_r_q     <= '0;
            b_r_q     <= '0;
            carry_q   <= 1'b0;
            idx_q     <= '0;
            partial_q <= '0;
            s_q       <= '0;
            cf_q      <= 1'b0;
            of_q      <= 1'b0;
            zf_q      <= 1'b0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_r_q     <= a_r_d;
            b_r_q     <= b_r_d;
            carry_q   <= carry_d;
            idx_q     <= idx_d;
            partial_q <= partial_d;
            s_q       <= s_d;
            cf_q      <= cf_d;
            of_q      <= of_d;
            zf_q      <= zf_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign ready = ready_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign s     = s_q;
    assign cf    = cf_q;
    assign of    = of_q;
    assign zf    = zf_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - directed bench with an arithmetic reference model for nibble_serial_adder

module tb_nibble_serial_adder;
    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sub;
    logic [W-1:0] a, b;
    logic         ready, busy, done;
    logic [W-1:0] s;
    logic         cf, of, zf;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    bit chk_en   = 1'b0;

    nibble_serial_adder #(.NIBBLES(NIBBLES)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .cf    (cf),
        .of    (of),
        .zf    (zf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 = idle, 1..NIBBLES = computing, NIBBLES+1 = result cycle.
    int           m_phase;
    logic [W-1:0] m_s, p_s;
    logic         m_cf, m_of, m_zf, p_cf, p_of, p_zf;

    always @(posedge clk) begin
        longint ua, ub, sa, sb, r, sr;
        if (rst) begin
            m_phase <= 0;
            m_s <= '0; m_cf <= 1'b0; m_of <= 1'b0; m_zf <= 1'b0;
        end else if (m_phase == 0) begin
            if (start) begin
                ua = longint'(a);
                ub = longint'(b);
                sa = (ua >= (64'sd1 << (W - 1))) ? ua - (64'sd1 << W) : ua;
                sb = (ub >= (64'sd1 << (W - 1))) ? ub - (64'sd1 << W) : ub;
                if (sub) begin
                    r    = ua - ub;
                    sr   = sa - sb;
                    p_cf <= (ua >= ub);
                end else begin
                    r    = ua + ub;
                    sr   = sa + sb;
                    p_cf <= (r >= (64'sd1 << W));
                end
                r    = r & ((64'sd1 << W) - 1);
                p_s  <= W'(r);
                p_zf <= (r == 0);
                p_of <= (sr >= (64'sd1 << (W - 1))) || (sr < -(64'sd1 << (W - 1)));
                m_phase <= 1;
            end
        end else if (m_phase == NIBBLES) begin
            m_s <= p_s; m_cf <= p_cf; m_of <= p_of; m_zf <= p_zf;
            m_phase <= NIBBLES + 1;
        end else if (m_phase == NIBBLES + 1) begin
            m_phase <= 0;
        end else begin
            m_phase <= m_phase + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("ready", ready, m_phase == 0);
            check("busy", busy, (m_phase >= 1) && (m_phase <= NIBBLES));
            check("done", done, m_phase == NIBBLES + 1);
            check("one_hot_status", int'(ready) + int'(busy) + int'(done), 1);
            check("s", s, m_s);
            check("cf", cf, m_cf);
            check("of", of, m_of);
            check("zf", zf, m_zf);
            if (done) done_cnt++;
        end
    end

    task automatic run_op(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic ts, input logic [W-1:0] es, input logic ecf,
                          input logic eof, input logic ezf);
        int lat;
        @(negedge clk);
        a = ta; b = tb_v; sub = ts; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = ~ta; b = ~tb_v; sub = ~ts;
        lat = 1;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({nm, "_latency"}, lat, NIBBLES + 1);
        check({nm, "_s"}, s, es);
        check({nm, "_cf"}, cf, ecf);
        check({nm, "_of"}, of, eof);
        check({nm, "_zf"}, zf, ezf);
        check({nm, "_model_s"}, m_s, es);
        @(negedge clk);
        check({nm, "_ready_after"}, ready, 1);
    endtask

    initial begin
        int lat, d0;
        rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check("reset_ready", ready, 1);
        check("reset_s", s, 0);
        @(negedge clk);
        rst = 1'b0;

        run_op("basic_add",  16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
        run_op("ripple",     16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        run_op("ovf_add",    16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        run_op("ovf_sub",    16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        run_op("borrow_sub", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        run_op("equal_sub",  16'h0007, 16'h0007, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);

        // start held and operands churned throughout RUN and DONE must not launch anything
        d0 = done_cnt;
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        a = 16'hFFFF;
        lat = 1;
        while (!done && lat < 20) begin
            @(negedge clk);
            a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
            lat++;
        end
        start = 1'b0;
        check("hs_latency", lat, NIBBLES + 1);
        check("hs_s", s, 16'h3333);
        repeat (4) @(negedge clk);
        check("hs_single_done", done_cnt - d0, 1);
        check("hs_no_restart", busy, 0);

        // reset sampled on the second RUN edge
        d0 = done_cnt;
        a = 16'h0F0F; b = 16'h0F0F; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_ready", ready, 1);
        check("rst_s", s, 0);
        check("rst_flags", {cf, of, zf, done, busy}, 0);
        repeat (NIBBLES + 2) @(negedge clk);
        check("rst_no_done", done_cnt - d0, 0);

        run_op("post_rst", 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-cycle W-bit add/subtract unit built around the existing 4-bit ripple slice `adder_4`, which is instantiated once and fed one operand nibble per clock. It is the sequencing stage directly upstream of `adder_4`:
- drives the slice's `a`, `b` and `cin` each cycle;
- consumes `s` and `cf` from the slice;
- chains the nibble carry through a register;
- assembles the full-width result with flags behind a start/done handshake.

## Interface
Parameters:
- NIBBLES, default 4: number of 4-bit slices per operation. W = 4*NIBBLES (16 by default). Legal range 2..8.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request an operation; sampled only while ready=1.
- sub  input  1  0 = a+b, 1 = a-b; sampled with start.
- a  input  W  operand A, sampled with start.
- b  input  W  operand B, sampled with start.
- ready  output  1  high in IDLE only; start is accepted only when ready=1.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse marking valid results.
- s  output  W  result, two's-complement/unsigned sum or difference.
- cf  output  1  carry out of the MSB nibble; for sub, 1 = no borrow.
- of  output  1  signed overflow.
- zf  output  1  s == 0.

## Operation
States: IDLE, RUN, DONE.

- **IDLE, start=1 at an edge:**
  - latch a_r = a;
  - latch b_r = sub ? ~b : b;
  - carry_r = sub;
  - idx = 0;
  - clear the internal partial-result register;
  - latch sub_r;
  - go to RUN.
- **IDLE, start=0:** stay in IDLE. Outputs hold their last values.
- **RUN, each edge:**
  - `adder_4` inputs: a = a_r[4*idx+3:4*idx], b = b_r[4*idx+3:4*idx], cin = carry_r;
  - write the slice `s` into partial[4*idx+3:4*idx];
  - carry_r ← slice `cf`;
  - idx ← idx+1.
- **RUN, edge where idx == NIBBLES-1:** in addition to the above:
  - s ← full assembled result, including this final nibble;
  - cf ← slice cf;
  - zf ← (assembled result == 0);
  - of ← (a_r[W-1] == b_r[W-1]) && (result[W-1] != a_r[W-1]);
  - done ← 1;
  - go to DONE.
- **DONE:** one cycle, done=1. At the next edge: done ← 0 and go to IDLE. start is ignored in DONE.
- start asserted while ready=0 (RUN or DONE) is ignored; it is not queued.
- a, b and sub may change freely after acceptance; only the latched copies are used.
- s, cf, of and zf change only at the completion edge. They hold from then until the next completion or reset. The partial result is never visible on s.
- Arithmetic is modulo 2^W. No saturation.

## Timing
- Reset, at any edge with rst=1, overriding all else including mid-RUN:
  - state = IDLE, idx = 0, carry_r = 0;
  - s = 0, cf = 0, of = 0, zf = 0;
  - done = 0, busy = 0, ready = 1.
  - An aborted operation produces no done pulse.
- Latency, with start sampled at edge E0:
  - RUN occupies edges E1..E_NIBBLES;
  - done and results are valid after edge E_NIBBLES, i.e. NIBBLES edges after acceptance;
  - done is high for exactly one cycle;
  - ready returns high after edge E_NIBBLES+1.
- Throughput: one operation per NIBBLES+2 cycles.
- ready, busy and done are mutually exclusive. Exactly one of ready/busy/done is high in every cycle after reset.
- rst=1 together with start=1: reset wins and the start is dropped.

## Test plan
- **Basic add:** reset, then start with a=0x1234, b=0x4321, sub=0 → done exactly 4 edges after acceptance; s=0x5555, cf=0, of=0, zf=0; ready high again 1 cycle after done.
- **Carry ripple across all nibbles:** a=0xFFFF, b=0x0001, add → s=0x0000, cf=1, zf=1, of=0.
- **Signed overflow:** a=0x7FFF, b=0x0001, add → s=0x8000, cf=0, of=1; then sub with a=0x8000, b=0x0001 → s=0x7FFF, cf=1, of=1.
- **Subtract with borrow:** a=0x0005, b=0x0007, sub=1 → s=0xFFFE, cf=0, of=0, zf=0; a=0x0007, b=0x0007, sub=1 → s=0x0000, cf=1, zf=1.
- **Handshake:** while an add of 0x1111+0x2222 is in RUN, pulse start with a=0xFFFF and change a/b every cycle → single done, s=0x3333, no second operation started.
- **Reset mid-operation:** assert rst at the second RUN edge → next cycle ready=1, s=0, all flags 0, no done pulse; a following add of 0x0F0F+0x00F1 → s=0x1000.
